// File: rtl/taillight_sequencer.sv
// Six-lamp tail light sequencer: arbitrates turn/hazard/brake into a 3-step sweep.
// Optional BRAKE_OVERLAY_EN lights the non-signalling side while braking.
module taillight_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
    input  logic       brake,
    output logic       LA,
    output logic       LB,
    output logic       LC,
    output logic       RA,
    output logic       RB,
    output logic       RC,
    output logic [1:0] mode,
    output logic [1:0] step,
    output logic       tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_1    = 2'd1;
    localparam logic [1:0] S_2    = 2'd2;
    localparam logic [1:0] S_3    = 2'd3;

    localparam logic [1:0] M_IDLE  = 2'b00;
    localparam logic [1:0] M_LEFT  = 2'b01;
    localparam logic [1:0] M_RIGHT = 2'b10;
    localparam logic [1:0] M_HAZ   = 2'b11;

    logic [CW-1:0] cnt;
    logic [1:0]    arb_mode;
    logic          req;
    logic [1:0]    step_n;
    logic [1:0]    mode_n;
    logic [2:0]    sweep;
    logic [2:0]    lamp_l;
    logic [2:0]    lamp_r;

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // left+right together is treated as a hazard request
    always_comb begin
        req = hazard | left | right;
        if (hazard || (left && right)) begin
            arb_mode = M_HAZ;
        end else if (left) begin
            arb_mode = M_LEFT;
        end else if (right) begin
            arb_mode = M_RIGHT;
        end else begin
            arb_mode = M_IDLE;
        end
    end

    always_comb begin
        step_n = step;
        mode_n = mode;
        if (tick) begin
            unique case (step)
                S_1: step_n = S_2;
                S_2: step_n = S_3;
                S_IDLE, S_3: begin
                    if (req) begin
                        step_n = S_1;
                        mode_n = arb_mode;
                    end else begin
                        step_n = S_IDLE;
                        mode_n = M_IDLE;
                    end
                end
            endcase
        end
    end

    // Lamps track the next state so they move on the same edge as step/mode
    always_comb begin
        sweep  = {step_n != S_IDLE, step_n >= S_2, step_n == S_3};
        lamp_l = mode_n[0] ? sweep : 3'b000;
        lamp_r = mode_n[1] ? sweep : 3'b000;
        if (step_n == S_IDLE && brake) begin
            lamp_l = 3'b111;
            lamp_r = 3'b111;
        end
`ifdef BRAKE_OVERLAY_EN
        if (brake && mode_n == M_LEFT) begin
            lamp_r = 3'b111;
        end
        if (brake && mode_n == M_RIGHT) begin
            lamp_l = 3'b111;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            step         <= S_IDLE;
            mode         <= M_IDLE;
            {LA, LB, LC} <= 3'b000;
            {RA, RB, RC} <= 3'b000;
        end else begin
            step         <= step_n;
            mode         <= mode_n;
            {LA, LB, LC} <= lamp_l;
            {RA, RB, RC} <= lamp_r;
        end
    end

endmodule

// File: tb/tb_taillight_sequencer.sv
// Scoreboard bench for taillight_sequencer: a behavioural model pushes the
// expected output word per edge; it is popped and compared after the edge.
module tb_taillight_sequencer;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       hazard = 1'b0;
    logic       brake = 1'b0;
    logic       LA, LB, LC, RA, RB, RC;
    logic [1:0] mode;
    logic [1:0] step;
    logic       tick;

    typedef logic [10:0] obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int         m_cnt = 0;
    int         m_step = 0;
    int         m_mode = 0;
    logic [2:0] m_l = 3'b000;
    logic [2:0] m_r = 3'b000;
    logic       m_tick = 1'b0;

    always #5 clk = ~clk;

    taillight_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk    (clk),
        .Reset  (Reset),
        .left   (left),
        .right  (right),
        .hazard (hazard),
        .brake  (brake),
        .LA     (LA),
        .LB     (LB),
        .LC     (LC),
        .RA     (RA),
        .RB     (RB),
        .RC     (RC),
        .mode   (mode),
        .step   (step),
        .tick   (tick)
    );

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t observe();
        return {mode, step, LA, LB, LC, RA, RB, RC, tick};
    endfunction

    // Model of the state after the coming edge, from the inputs now applied
    task automatic model_push();
        bit         tk;
        logic [2:0] sw;
        tk = (m_cnt == TICK_DIV - 1);
        if (Reset) begin
            m_cnt  = 0;
            m_step = 0;
            m_mode = 0;
            m_l    = 3'b000;
            m_r    = 3'b000;
        end else begin
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) begin
                if (m_step == 0 || m_step == 3) begin
                    if (hazard || (left && right)) m_mode = 3;
                    else if (left) m_mode = 1;
                    else if (right) m_mode = 2;
                    else m_mode = 0;
                    m_step = (m_mode != 0) ? 1 : 0;
                end else begin
                    m_step = m_step + 1;
                end
            end
            sw  = 3'b111 << (3 - m_step);
            m_l = (m_mode == 1 || m_mode == 3) ? sw : 3'b000;
            m_r = (m_mode == 2 || m_mode == 3) ? sw : 3'b000;
            if (m_step == 0 && brake) begin
                m_l = 3'b111;
                m_r = 3'b111;
            end
`ifdef BRAKE_OVERLAY_EN
            if (brake && m_mode == 1) m_r = 3'b111;
            if (brake && m_mode == 2) m_l = 3'b111;
`endif
        end
        m_tick = (m_cnt == TICK_DIV - 1);
        sb.push_back({2'(m_mode), 2'(m_step), m_l, m_r, m_tick});
    endtask

    task automatic cycle(input string tag);
        obs_t e;
        model_push();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 11'd0, 11'd1);
        end else begin
            e = sb.pop_front();
            check(tag, observe(), e);
        end
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        left   = 1'b0;
        right  = 1'b0;
        hazard = 1'b0;
        brake  = 1'b0;
        cycle("rst");
        cycle("rst");
        Reset = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        check("reset_out", observe(), 11'd0);

        // left held from reset
        left = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cycle("left_hold");
            if (i == 3) check("e3_step", 11'(step), 11'd0);
            if (i == 4) check("e4_L", 11'({step, LA, LB, LC}), 11'b01_100);
            if (i == 8) check("e8_L", 11'({step, LA, LB, LC}), 11'b10_110);
            if (i == 12) check("e12_LR", 11'({step, LA, LB, LC, RA, RB, RC}), 11'b11_111_000);
            if (i == 16) check("e16_L", 11'({step, LA, LB, LC}), 11'b01_100);
        end

        // release during S1
        do_reset();
        left = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cycle("left_rel");
            if (i == 4) left = 1'b0;
            if (i == 12) check("rel_s3", 11'(step), 11'd3);
            if (i == 16) check("rel_idle", observe(), 11'd0);
        end

        // left+right as hazard, then hazard+right
        do_reset();
        left  = 1'b1;
        right = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cycle("lr_haz");
            if (i == 4) begin
                check("lr_mode", 11'({mode, LA, LB, LC, RA, RB, RC}), 11'b11_100_100);
                left   = 1'b0;
                hazard = 1'b1;
            end
            if (i == 12) check("haz_all", 11'({LA, LB, LC, RA, RB, RC}), 11'b111_111);
            if (i == 16) check("hr_mode", 11'(mode), 11'd3);
        end

        // right then switch to left during S2
        do_reset();
        right = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cycle("r_to_l");
            if (i == 8) begin
                right = 1'b0;
                left  = 1'b1;
            end
            if (i == 12) check("r_s3", 11'({mode, step, RA, RB, RC}), 11'b10_11_111);
            if (i == 16) check("l_next", 11'({mode, LA, LB, LC, RA, RB, RC}), 11'b01_100_000);
        end

        // brake in idle, then left sweep with brake
        do_reset();
        brake = 1'b1;
        cycle("brake_idle");
        check("brake_all", 11'({LA, LB, LC, RA, RB, RC}), 11'b111_111);
        left = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            cycle("brake_left");
            if (i == 4) begin
`ifdef BRAKE_OVERLAY_EN
                check("brk_ovl", 11'({LA, LB, LC, RA, RB, RC}), 11'b100_111);
`else
                check("brk_ovl", 11'({LA, LB, LC, RA, RB, RC}), 11'b100_000);
`endif
            end
        end
        brake = 1'b0;
        cycle("brake_off");

        // reset mid-sweep (S2)
        do_reset();
        left = 1'b1;
        for (int i = 1; i <= 8; i++) cycle("pre_rst");
        check("pre_rst_s2", 11'(step), 11'd2);
        Reset = 1'b1;
        cycle("mid_rst");
        check("mid_rst_out", observe(), 11'd0);
        Reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cycle("post_rst");
            if (i == 3) check("post_e3", 11'({LA, tick}), 11'b01);
            if (i == 4) check("post_e4", 11'({LA, step}), 11'b1_01);
        end

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) left = 1'($urandom);
            if ($urandom_range(0, 5) == 0) right = 1'($urandom);
            if ($urandom_range(0, 9) == 0) hazard = 1'($urandom);
            if ($urandom_range(0, 3) == 0) brake = 1'($urandom);
            Reset = ($urandom_range(0, 60) == 0);
            cycle("rand");
        end
        Reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/taillight_sequencer.md
# taillight_sequencer

Arbitrating sequencer for the six tail lights (LA, LB, LC, RA, RB, RC).
- Resolves the driver's left, right, hazard and brake controls into a single active mode.
- Divides `clk` down to a programmable step tick and runs the three-step sweep one step per tick.
- Changes mode only at sequence boundaries, so a sweep is never cut short.
- Sits between the steering-column/pedal inputs and the lamp drivers; it is the sole owner of the light outputs.

## Interface
- `TICK_DIV`, default 4: `clk` cycles per sweep step. Legal range ≥1. Divider width is `$clog2(TICK_DIV)`, minimum 1 bit.
- `clk` in 1: rising-edge clock, the only clock.
- `Reset` in 1: synchronous, active-high reset.
- `left` in 1: left turn request, level, synchronous to `clk`.
- `right` in 1: right turn request, level.
- `hazard` in 1: hazard request, level.
- `brake` in 1: brake pedal, level.
- `LA`, `LB`, `LC` out 1 each: left lamps, inner to outer, registered.
- `RA`, `RB`, `RC` out 1 each: right lamps, inner to outer, registered.
- `mode` out 2: active mode, registered. 00 idle, 01 left, 10 right, 11 hazard.
- `step` out 2: sweep step, registered. 0 idle, 1–3 sweep.
- `tick` out 1: one-cycle step strobe.

## Operation
- **Divider**
  - `cnt` counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` = (`cnt` == TICK_DIV-1).
  - With TICK_DIV=1, `tick` is constantly 1.
- **Arbitration**
  - Evaluated only on a `tick` while `step` is 0 or 3.
  - Priority: `hazard`, then (`left` & `right`) which counts as hazard, then `left`, then `right`.
- **States** (`step`): IDLE(0), S1, S2, S3. All transitions happen only on `tick` edges; between ticks everything holds.
  - IDLE: if any request → S1 with the arbitrated mode; otherwise stay IDLE with `mode` = 00.
  - S1 → S2 → S3 unconditionally.
  - S3: if any request → S1 with the newly arbitrated mode (back-to-back sweeps, no IDLE gap); otherwise → IDLE with `mode` = 00.
- **Mid-sweep input changes** (S1/S2) are ignored. A released or changed request takes effect only at the S3 boundary.
- **Light patterns** (outer lamps never lit before inner):
  - Left: S1 = LA; S2 = LA, LB; S3 = LA, LB, LC.
  - Right: mirrored on RA, RB, RC.
  - Hazard: both sides sweep together (S1 = LA+RA, S2 = LA,LB,RA,RB, S3 = all six).
  - IDLE: all off, unless brake is asserted.
- **Brake** in IDLE: all six lamps on.
- **Reset values**: all lamps 0, `mode` 00, `step` 0, `cnt` 0, `tick` 0 (the tick=1 exception for TICK_DIV=1 is under Timing).

## Timing
- Lamp outputs are registered and computed from next-state and the current `brake`. Lamps change on the same edge as `step`/`mode`; `brake` has 1 cycle of latency.
- First tick after reset release occurs in cycle TICK_DIV-1, i.e. `cnt` goes 0,1,2,3 for TICK_DIV=4. A request held from reset therefore lights LA on edge TICK_DIV after reset deassertion.
- Sweep period is 3·TICK_DIV cycles when back-to-back, or 4·TICK_DIV cycles when passing through IDLE.
- A request that rises and falls entirely between ticks is lost; no latching.
- `Reset` is synchronous and dominates every other input, including mid-sweep: on the next edge all state returns to reset values and `cnt` returns to 0.
- TICK_DIV=1: `tick` reads 1 even during reset, since it is purely combinational on `cnt`.

## Configuration
- `BRAKE_OVERLAY_EN`
  - **Defined**: during a left sweep with `brake`=1, RA, RB, RC are forced on; during a right sweep, LA, LB, LC are forced on. Hazard sweeps are unaffected.
  - **Undefined**: `brake` is ignored whenever `mode` ≠ 00. The signalling side's pattern is identical in both builds.

## Test plan
- TICK_DIV=4, `left`=1 held from reset release → `step` reaches 1 at edge 4, 2 at edge 8, 3 at edge 12, then 1 at edge 16. Lamps {LA,LB,LC} go 100, 110, 111, 100; R lamps stay 000.
- `left`=1 for one tick, then released during S1 → sweep completes S2, S3, then IDLE at edge 16 with all lamps 0 and `mode` 00.
- `left`=`right`=1 → `mode` 11 and both sides sweep; `hazard`=1 with `right`=1 → `mode` 11.
- `right` sweeping, switch to `left` during S2 → right sweep completes S3; next tick gives `mode` 01 with LA only and RA..RC 0.
- IDLE with `brake`=1 → all six lamps on one cycle later. With BRAKE_OVERLAY_EN, a left sweep plus brake → RA..RC=111 while LA..LC sweep; without the macro, RA..RC=000.
- `Reset` asserted for one cycle during S2 → next edge gives all outputs 0 and `cnt` 0; with the request still held, LA relights TICK_DIV edges after reset deassertion.
